// File: rtl/cs_pkg.sv
// Shared definitions for the compressed-sensing measurement engine.
//   N_SAMPLES / M_MEAS / DATA_W : default frame geometry and sample width
//   state_t                     : engine state (ACCUM, DRAIN)
//   acc_width()                 : accumulator width that can never overflow
package cs_pkg;

  localparam int N_SAMPLES = 256;
  localparam int M_MEAS    = 64;
  localparam int DATA_W    = 12;

  typedef enum logic {
    ACCUM,
    DRAIN
  } state_t;

  // Worst case |y| = n * 2^(dw-1), which needs dw + log2(n) + 1 signed bits.
  function automatic int acc_width(input int n, input int dw);
    return dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cs_mac_lane.sv
// One signed measurement accumulator (one row of the sensing matrix).
// Ports:
//   clk      in   clock, rising edge
//   en       in   update the accumulator this cycle
//   load     in   first sample of a frame: start from zero instead of acc
//   sign     in   1 = add x, 0 = subtract x
//   x        in   sign-extended sample, ACC_W bits
//   acc      out  registered accumulator value
//   acc_next out  value acc takes on the next enabled edge
// The accumulator has no reset; the first sample of each frame loads it.
module cs_mac_lane
  import cs_pkg::*;
#(
  parameter int ACC_W = 21
) (
  input  logic             clk,
  input  logic             en,
  input  logic             load,
  input  logic             sign,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next
);

  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] term;

  always_comb begin
    base     = load ? '0 : acc;
    term     = sign ? x : (~x + ACC_W'(1));
    acc_next = base + term;
  end

  always_ff @(posedge clk) begin
    if (en) acc <= acc_next;
  end

endmodule

// File: rtl/cs_measure_accum.sv
// Compressed-sensing measurement engine. Accumulates N_SAMPLES samples into
// M_MEAS signed measurements (+x when the PRBS bit is 1, -x when 0), then
// drains the measurements serially over a valid/ready port.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   in_sample / phi_col valid
//   in_ready   out  sample accepted this cycle (ACCUM only)
//   in_sample  in   ECG sample (two's complement, or offset-binary, see below)
//   phi_col    in   PRBS column, bit m is the sign for row m
//   out_valid  out  measurement valid
//   out_ready  in   downstream accepts measurement
//   out_data   out  signed measurement y[out_index]
//   out_index  out  row index of out_data
//   frame_done out  one-cycle pulse after the last measurement handshake
// Build option CS_DC_OFFSET_EN: in_sample is an unsigned ADC code and
// 2^(DATA_W-1) is removed before sign extension.
module cs_measure_accum
  import cs_pkg::*;
#(
  parameter int N_SAMPLES = cs_pkg::N_SAMPLES,
  parameter int M_MEAS    = cs_pkg::M_MEAS,
  parameter int DATA_W    = cs_pkg::DATA_W,
  parameter int ACC_W     = cs_pkg::acc_width(N_SAMPLES, DATA_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_sample,
  input  logic [M_MEAS-1:0]         phi_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [$clog2(M_MEAS)-1:0] out_index,
  output logic                      frame_done
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam int IDX_W = $clog2(M_MEAS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M_MEAS - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc;
  logic              accept;
  logic              hs;
  logic              last_sample;
  logic              last_meas;
  logic [DATA_W-1:0] x_c;
  logic [ACC_W-1:0]  x_ext;
  logic [ACC_W-1:0]  acc_q [M_MEAS];
  logic [ACC_W-1:0]  acc_d [M_MEAS];

  assign accept      = in_valid & in_ready;
  assign hs          = out_valid & out_ready;
  assign last_sample = accept && (cnt == CNT_LAST);
  assign last_meas   = hs && (idx == IDX_LAST);
  assign idx_inc     = idx + IDX_W'(1);
  assign out_index   = idx;

`ifdef CS_DC_OFFSET_EN
  // Subtracting 2^(DATA_W-1) from an offset-binary code is an MSB flip.
  assign x_c = {~in_sample[DATA_W-1], in_sample[DATA_W-2:0]};
`else
  assign x_c = in_sample;
`endif

  assign x_ext = {{(ACC_W - DATA_W){x_c[DATA_W-1]}}, x_c};

  for (genvar m = 0; m < M_MEAS; m++) begin : g_lane
    cs_mac_lane #(.ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .en       (accept),
      .load     (cnt == '0),
      .sign     (phi_col[m]),
      .x        (x_ext),
      .acc      (acc_q[m]),
      .acc_next (acc_d[m])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (last_sample) state_next = DRAIN;
      DRAIN: if (last_meas)   state_next = ACCUM;
      default:                state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      in_ready   <= (state_next == ACCUM);
      frame_done <= last_meas;
      if (accept) cnt <= last_sample ? '0 : cnt + CNT_W'(1);
      // Row 0 is captured from the lane's next value so the first
      // measurement is valid the cycle right after the final accept.
      if (last_sample) begin
        out_valid <= 1'b1;
        out_data  <= acc_d[0];
        idx       <= '0;
      end else if (hs) begin
        if (last_meas) begin
          out_valid <= 1'b0;
          idx       <= '0;
        end else begin
          idx      <= idx_inc;
          out_data <= acc_q[idx_inc];
        end
      end
    end
  end

endmodule
